// File: rtl/mimo_slicer_demap.sv
// 4-PAM slicer and Gray demapper streaming LANES codes per beat.
// Optional SLICER_CLIP_CNT_EN adds a saturating clip counter.
module mimo_slicer_demap #(
    parameter int DIMENSION = 16,
    parameter int WIDTH     = 8,
    parameter int FRAC      = 4,
    parameter int LANES     = 4,
    localparam int NB       = DIMENSION / LANES,
    localparam int IW       = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       x_valid,
    output logic                       x_ready,
    input  logic [DIMENSION*WIDTH-1:0] x_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*LANES-1:0]         out_bits,
    output logic [IW-1:0]              out_idx,
    output logic                       out_last,
`ifdef SLICER_CLIP_CNT_EN
    output logic                       busy,
    input  logic                       clip_clr,
    output logic [15:0]                clip_cnt
`else
    output logic                       busy
`endif
);

    localparam int CW = 2 * DIMENSION;
    localparam int T  = 2 << FRAC;

    logic [CW-1:0] work_q;
    logic [CW-1:0] pend_q;
    logic          pend_full;
    logic          valid_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] x_codes;
    logic          fire_in;
    logic          fire_out;
    logic          last_fire;
    logic          to_work;
    logic          to_pend;

    function automatic logic [CW-1:0] slice_vec(
        input logic [DIMENSION*WIDTH-1:0] v
    );
        logic [CW-1:0]           c;
        logic signed [WIDTH-1:0] e;
        c = '0;
        for (int k = 0; k < DIMENSION; k++) begin
            e = v[k*WIDTH +: WIDTH];
            if (int'(e) >= T)
                c[2*k +: 2] = 2'b10;
            else if (int'(e) >= 0)
                c[2*k +: 2] = 2'b11;
            else if (int'(e) >= -T)
                c[2*k +: 2] = 2'b01;
            else
                c[2*k +: 2] = 2'b00;
        end
        return c;
    endfunction

    assign x_codes   = slice_vec(x_in);
    assign x_ready   = en & ~rst & ~pend_full;
    assign fire_in   = x_valid & x_ready;
    assign fire_out  = valid_q & out_ready & en;
    assign last_fire = fire_out & out_last;
    // Working buffer frees on the last beat; pending gets first claim on it.
    assign to_work   = fire_in & (~valid_q | (last_fire & ~pend_full));
    assign to_pend   = fire_in & ~to_work;

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_last  = valid_q & (idx_q == IW'(NB - 1));
    assign out_bits  = work_q[int'(idx_q)*2*LANES +: 2*LANES];
    assign busy      = valid_q | pend_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q    <= '0;
            pend_q    <= '0;
            pend_full <= 1'b0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
        end else if (en) begin
            if (to_pend) begin
                pend_q    <= x_codes;
                pend_full <= 1'b1;
            end
            if (last_fire) begin
                idx_q <= '0;
                if (pend_full) begin
                    work_q    <= pend_q;
                    pend_full <= 1'b0;
                end else if (to_work) begin
                    work_q <= x_codes;
                end else begin
                    valid_q <= 1'b0;
                end
            end else if (fire_out) begin
                idx_q <= idx_q + 1'b1;
            end else if (to_work) begin
                work_q  <= x_codes;
                valid_q <= 1'b1;
                idx_q   <= '0;
            end
        end
    end

`ifdef SLICER_CLIP_CNT_EN
    localparam int C = 4 << FRAC;

    logic [4:0]  clip_n;
    logic [16:0] clip_sum;

    always_comb begin
        logic signed [WIDTH-1:0] e;
        clip_n = '0;
        for (int k = 0; k < DIMENSION; k++) begin
            e = x_in[k*WIDTH +: WIDTH];
            if (int'(e) > C || int'(e) < -C)
                clip_n = clip_n + 5'd1;
        end
    end

    assign clip_sum = {1'b0, clip_cnt} + 17'(clip_n);

    always_ff @(posedge clk) begin
        if (rst)
            clip_cnt <= '0;
        else if (en) begin
            if (clip_clr)
                clip_cnt <= '0;
            else if (fire_in)
                clip_cnt <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_mimo_slicer_demap.sv
// Scoreboard bench for mimo_slicer_demap.
// Reference model slices by value rules and tracks vector occupancy.
module tb_mimo_slicer_demap;

    localparam int DIMENSION = 16;
    localparam int WIDTH     = 8;
    localparam int FRAC      = 4;
    localparam int LANES     = 4;
    localparam int NB        = DIMENSION / LANES;
    localparam int IW        = 2;
    localparam int VW        = DIMENSION * WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          x_valid = 1'b0;
    logic          x_ready;
    logic [VW-1:0] x_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_bits;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;
`ifdef SLICER_CLIP_CNT_EN
    logic          clip_clr = 1'b0;
    logic [15:0]   clip_cnt;
`endif

    mimo_slicer_demap #(
        .DIMENSION(DIMENSION), .WIDTH(WIDTH),
        .FRAC(FRAC), .LANES(LANES)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .x_valid(x_valid), .x_ready(x_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .out_idx(out_idx),
        .out_last(out_last),
`ifdef SLICER_CLIP_CNT_EN
        .busy(busy), .clip_clr(clip_clr), .clip_cnt(clip_cnt)
`else
        .busy(busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bits;
        int         idx;
        bit         last;
    } beat_t;

    beat_t q[$];
    int    tests = 0;
    int    fails = 0;
    int    inflight = 0;
    int    exp_clip = 0;
    bit    prev_rst = 1'b1;
    bit    started = 1'b0;

    function automatic int code_of(int v);
        int t;
        t = 2 * (2 ** FRAC);
        if (v >= t) return 2;
        if (v >= 0) return 3;
        if (v >= -t) return 1;
        return 0;
    endfunction

    function automatic int elem(logic [VW-1:0] v, int k);
        logic signed [WIDTH-1:0] e;
        e = v[k*WIDTH +: WIDTH];
        return int'(e);
    endfunction

    task automatic check(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push_vec(logic [VW-1:0] v);
        beat_t b;
        int    c;
        for (int j = 0; j < NB; j++) begin
            b.bits = '0;
            for (int l = 0; l < LANES; l++) begin
                c = code_of(elem(v, j*LANES + l));
                b.bits[2*l +: 2] = 2'(c);
            end
            b.idx  = j;
            b.last = (j == NB - 1);
            q.push_back(b);
        end
    endtask

    always @(posedge clk) started <= 1'b1;

    always @(negedge clk) begin
        if (started) begin
            if (prev_rst) begin
                check("rst_bits", out_bits, 0);
                check("rst_idx", out_idx, 0);
                check("rst_last", out_last, 0);
            end
            check("out_valid", out_valid, inflight > 0);
            check("busy", busy, inflight > 0);
            check("x_ready", x_ready,
                  en && !rst && inflight < 2);
            if (out_valid && q.size() > 0) begin
                check("beat_bits", out_bits, q[0].bits);
                check("beat_idx", out_idx, q[0].idx);
                check("beat_last", out_last, q[0].last);
            end
`ifdef SLICER_CLIP_CNT_EN
            check("clip_cnt", clip_cnt, exp_clip);
`endif
            if (rst) begin
                q.delete();
                inflight = 0;
                exp_clip = 0;
            end else begin
                if (out_valid && out_ready && en && q.size() > 0) begin
                    if (q[0].last) inflight--;
                    void'(q.pop_front());
                end
                if (x_valid && x_ready) begin
                    push_vec(x_in);
                    inflight++;
                end
`ifdef SLICER_CLIP_CNT_EN
                if (en) begin
                    if (clip_clr) exp_clip = 0;
                    else if (x_valid && x_ready) begin
                        for (int k = 0; k < DIMENSION; k++)
                            if (elem(x_in, k) > 64 || elem(x_in, k) < -64)
                                exp_clip++;
                        if (exp_clip > 65535) exp_clip = 65535;
                    end
                end
`endif
            end
            prev_rst = rst;
        end
    end

    task automatic send_vec(logic [VW-1:0] v);
        bit ok;
        ok = 1'b0;
        x_in = v;
        x_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (x_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 x_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        logic [7:0]    pick [14];
        pick = '{8'h00, 8'h1F, 8'h20, 8'h21, 8'hE0, 8'hDF, 8'hE1,
                 8'hFF, 8'h7F, 8'h80, 8'h40, 8'h41, 8'hBF, 8'hC0};
        for (int k = 0; k < DIMENSION; k++)
            if ($urandom_range(1, 0) == 1)
                v[k*WIDTH +: WIDTH] = pick[$urandom_range(13, 0)];
            else
                v[k*WIDTH +: WIDTH] = 8'($urandom);
        return v;
    endfunction

    logic [VW-1:0] v;
    int            run;
    bit            seen;

    initial begin
        x_valid = 1'b1;
        x_in = {DIMENSION{8'h30}};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        x_valid = 1'b0;

        send_vec({DIMENSION{8'h30}});
        wait_idle();

        v = '0;
        v[31:0] = 32'hDFE02000;
        send_vec(v);
        wait_idle();

        out_ready = 1'b0;
        send_vec(rand_vec());
        send_vec(rand_vec());
        fork
            send_vec(rand_vec());
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_idle();

        run = 0;
        seen = 1'b0;
        fork
            begin
                send_vec(rand_vec());
                send_vec(rand_vec());
                send_vec(rand_vec());
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        run++;
                    end else if (seen) begin
                        break;
                    end
                end
            end
        join
        check("b2b_run", run, 12);
        wait_idle();

        send_vec(rand_vec());
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && out_idx == 0) break;
        end
        @(posedge clk);
        #1 en = 1'b0;
        repeat (3) @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle();

        v = '0;
        v[15:0] = 16'h807F;
        send_vec(v);
        wait_idle();
`ifdef SLICER_CLIP_CNT_EN
        clip_clr = 1'b1;
        @(posedge clk);
        #1 clip_clr = 1'b0;
`endif

        for (int i = 0; i < 600; i++) begin
            en        = ($urandom_range(7, 0) != 0);
            x_valid   = ($urandom_range(1, 0) == 1);
            out_ready = ($urandom_range(3, 0) != 0);
            x_in      = rand_vec();
            rst       = ($urandom_range(149, 0) == 0);
`ifdef SLICER_CLIP_CNT_EN
            clip_clr  = ($urandom_range(49, 0) == 0);
`endif
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        en = 1'b1;
        x_valid = 1'b0;
        out_ready = 1'b1;
`ifdef SLICER_CLIP_CNT_EN
        clip_clr = 1'b0;
`endif
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
